// File: rtl/transmitting_piso.sv
// rtl/transmitting_piso.sv - parallel-in/serial-out frame transmitter, LSB first, with end-of-frame pulse
module transmitting_piso #(
    parameter int FRAME_BITS   = 10,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [FRAME_BITS-1:0] data_in,
    input  logic                  load_n,
    output logic                  data_out,
    output logic                  charSent
);

    localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         bit_tmr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            bit_tmr  <= '0;
            data_out <= 1'b1;
            charSent <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    data_out <= 1'b1;
                    charSent <= 1'b0;
                    if (!load_n) begin
                        shreg <= data_in;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!load_n) begin
                        shreg    <= data_in;
                        data_out <= 1'b1;
                    end else begin
                        // Bit 0 goes on the line on the same edge that leaves LOAD.
                        data_out <= shreg[0];
                        bit_cnt  <= '0;
                        bit_tmr  <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_tmr == LAST_TICK) begin
                        bit_tmr <= '0;
                        if (bit_cnt != LAST_BIT) begin
                            shreg    <= shreg >> 1;
                            bit_cnt  <= bit_cnt + CW'(1);
                            data_out <= shreg[1];
                        end else begin
                            data_out <= 1'b1;
                            charSent <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + TW'(1);
                    end
                end
                DONE: begin
                    data_out <= 1'b1;
                    charSent <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    data_out <= 1'b1;
                    charSent <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitting_piso.sv
// tb/tb_transmitting_piso.sv - scoreboard bench for transmitting_piso
module tb_transmitting_piso;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [9:0] data_in;
    logic       load_n;
    logic       data_out;
    logic       charSent;

    typedef struct {
        logic [9:0] frame;
        int         stall_bit;
        int         stall_len;
    } exp_t;

    exp_t exp_q[$];
    logic hist[$];
    logic prev_cs;
    int   total;
    int   bad;

    transmitting_piso #(.FRAME_BITS(10), .CLKS_PER_BIT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_in  (data_in),
        .load_n   (load_n),
        .data_out (data_out),
        .charSent (charSent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_frame();
        exp_t e;
        int   len;
        int   idx;
        int   d;
        int   errs;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_charSent: got charSent=1 at %0t, required no pulse", $time);
        end else begin
            e   = exp_q.pop_front();
            len = 160 + ((e.stall_bit >= 0) ? e.stall_len : 0);
            total++;
            if (hist.size() < len) begin
                bad++;
                $display("FAIL frame_history: got %0d samples, required %0d", hist.size(), len);
            end else begin
                idx = hist.size() - len;
                for (int k = 0; k < 10; k++) begin
                    d    = 16 + ((k == e.stall_bit) ? e.stall_len : 0);
                    errs = 0;
                    for (int j = 0; j < d; j++) begin
                        if (hist[idx] !== e.frame[k]) errs++;
                        idx++;
                    end
                    total++;
                    if (errs != 0) begin
                        bad++;
                        $display("FAIL frame_%b_bit%0d: got %0d wrong samples of %0d, required all = %b",
                                 e.frame, k, errs, d, e.frame[k]);
                    end
                end
            end
            total++;
            if (data_out !== 1'b1) begin
                bad++;
                $display("FAIL idle_at_charSent: got data_out=%b, required 1", data_out);
            end
        end
    endtask

    // Monitor: charSent marks the end of a frame; the line history before it is checked.
    always @(negedge clk) begin
        if (charSent === 1'b1 && prev_cs !== 1'b1) check_frame();
        if (prev_cs === 1'b1) begin
            total++;
            if (charSent !== 1'b0) begin
                bad++;
                $display("FAIL charSent_width: got charSent=%b one cycle after pulse, required 0", charSent);
            end
        end
        prev_cs = charSent;
        hist.push_back(data_out);
        if (hist.size() > 400) void'(hist.pop_front());
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_frame(input logic [9:0] f, input int sb, input int sl);
        exp_t e;
        e.frame     = f;
        e.stall_bit = sb;
        e.stall_len = sl;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        total++;
        if (data_out !== 1'b1 || charSent !== 1'b0) begin
            bad++;
            $display("FAIL %s: got data_out=%b charSent=%b, required data_out=1 charSent=0",
                     name, data_out, charSent);
        end
    endtask

    task automatic load_frame(input logic [9:0] f, input int n);
        load_n  = 1'b0;
        data_in = f;
        cycles(n);
        load_n  = 1'b1;
    endtask

    initial begin
        logic found;
        total   = 0;
        bad     = 0;
        prev_cs = 1'b0;
        reset   = 1'b1;
        enable  = 1'b0;
        load_n  = 1'b1;
        data_in = '0;

        #2 reset = 1'b0;
        #1 check_idle("reset_async");
        enable  = 1'b1;
        load_n  = 1'b0;
        data_in = 10'h3FF;
        cycles(3);
        check_idle("reset_held");
        load_n = 1'b1;
        reset  = 1'b1;
        cycles(2);
        check_idle("idle_after_reset");

        // Basic frame, then load_n held high: no retransmit.
        expect_frame(10'b0110100101, -1, 0);
        load_frame(10'b0110100101, 4);
        cycles(200);
        check_idle("no_retransmit");

        // Enable stall of 5 clocks inside bit 3.
        expect_frame(10'b1001110010, 3, 5);
        load_frame(10'b1001110010, 2);
        cycles(50);
        enable = 1'b0;
        cycles(5);
        enable = 1'b1;
        cycles(150);

        // load_n/data_in activity during bit 4 must not disturb the frame.
        expect_frame(10'b0011011011, -1, 0);
        load_frame(10'b0011011011, 2);
        cycles(70);
        load_n  = 1'b0;
        data_in = 10'b1111111111;
        cycles(3);
        load_n  = 1'b1;
        cycles(120);

        // Reset during bit 6 aborts the frame with no charSent.
        load_frame(10'b1010101010, 2);
        cycles(101);
        reset = 1'b0;
        #1 check_idle("mid_frame_reset");
        cycles(3);
        check_idle("mid_frame_reset_held");
        reset = 1'b1;
        cycles(2);
        expect_frame(10'b1111100000, -1, 0);
        load_frame(10'b1111100000, 2);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycles(1);
            if (charSent === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL charSent_timeout: got no charSent in 300 cycles, required a pulse");
        end

        // Back-to-back: one-clock load pulse once IDLE is reached.
        cycles(1);
        expect_frame(10'b1100110110, -1, 0);
        load_frame(10'b1100110110, 1);
        cycles(1);
        total++;
        if (data_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_bit0: got data_out=%b after E0, required 0", data_out);
        end
        cycles(180);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL frames_outstanding: got %0d unsent frames, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
